// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Fetch-side datapath stage of the multi-cycle MIPS core. Holds the PC and
//   the instruction register, selects the next PC for the control unit's
//   PCSrc choice, slices IR fields for the downstream datapath and counts
//   retired instructions (PC advances).
//
// Ports
//   CLK        clock, all state updates on posedge
//   RST        asynchronous active-low reset
//   PCWre      PC write enable (IF)
//   IRWre      IR write enable (ID)
//   PCSrc      next-PC select: 00 PC+4, 01 branch, 10 JR, 11 J/JAL
//   rs_data    register-file port A, JR target
//   imem_rdata instruction memory read data
//   imem_addr  instruction memory byte address (= pc)
//   pc         current PC
//   pc_plus4   PC+4, also JAL link data
//   ir         instruction register
//   op/rs/rt/rd/sa/imm16  IR field slices
//   instret    PC advances since reset
//   misalign   sticky flag: a JR to a non-word-aligned rs_data was taken
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PCWre,
    input  logic             IRWre,
    input  logic [1:0]       PCSrc,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      imem_addr,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [31:0]      ir,
    output logic [5:0]       op,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       sa,
    output logic [15:0]      imm16,
    output logic [CNT_W-1:0] instret,
    output logic             misalign
);

    typedef enum logic [1:0] {
        SRC_SEQ    = 2'b00,
        SRC_BRANCH = 2'b01,
        SRC_JR     = 2'b10,
        SRC_JUMP   = 2'b11
    } pc_src_t;

    pc_src_t     pc_src;
    logic        first_fetch;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] jr_tgt;
    logic [31:0] next_pc;

    assign pc_src = pc_src_t'(PCSrc);

    // Field slices of the instruction register
    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign sa    = ir[10:6];
    assign imm16 = ir[15:0];

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    // Branch offset is always sign-extended, regardless of the extender mode
    assign br_tgt = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign j_tgt  = {pc_plus4[31:28], ir[25:0], 2'b00};
    assign jr_tgt = {rs_data[31:2], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            SRC_SEQ:    next_pc = pc_plus4;
            SRC_BRANCH: next_pc = br_tgt;
            SRC_JR:     next_pc = jr_tgt;
            SRC_JUMP:   next_pc = j_tgt;
            default:    next_pc = pc_plus4;
        endcase
    end

    // The first PCWre after reset only clears first_fetch so that the
    // instruction at RESET_PC is fetched rather than skipped.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc          <= RESET_PC;
            first_fetch <= 1'b1;
            instret     <= '0;
            misalign    <= 1'b0;
        end else if (PCWre) begin
            if (first_fetch) begin
                first_fetch <= 1'b0;
            end else begin
                pc      <= next_pc;
                instret <= instret + CNT_W'(1);
                if (pc_src == SRC_JR && rs_data[1:0] != 2'b00) begin
                    misalign <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ir <= '0;
        end else if (IRWre) begin
            ir <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit
//   Directed, self-checking bench for fetch_pc_unit. Each task drives one
//   scenario and compares outputs against hand-computed values.
module tb_fetch_pc_unit;

    logic        CLK;
    logic        RST;
    logic        PCWre;
    logic        IRWre;
    logic [1:0]  PCSrc;
    logic [31:0] rs_data;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] ir;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm16;
    logic [31:0] instret;
    logic        misalign;

    logic        use_mem;
    logic [31:0] rdata_drv;

    int checks;
    int failures;

    fetch_pc_unit #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PCWre      (PCWre),
        .IRWre      (IRWre),
        .PCSrc      (PCSrc),
        .rs_data    (rs_data),
        .imem_rdata (imem_rdata),
        .imem_addr  (imem_addr),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .ir         (ir),
        .op         (op),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .sa         (sa),
        .imm16      (imm16),
        .instret    (instret),
        .misalign   (misalign)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Optional instruction-memory model: word derived from the address
    always_comb imem_rdata = use_mem ? (imem_addr ^ 32'hDEAD_0000) : rdata_drv;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; PCWre = 1'b0; IRWre = 1'b0; PCSrc = 2'b00;
        rs_data = '0; rdata_drv = '0; use_mem = 1'b0;
        #1 RST = 1'b0;
        #2;
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (ir !== 32'h0) begin failures++; $display("FAIL reset_ir got=%h exp=%h", ir, 32'h0); end
        checks++; if (instret !== 32'h0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", instret); end
        checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
        checks++; if (op !== 6'h00) begin failures++; $display("FAIL reset_op got=%h exp=00", op); end
        checks++; if (pc_plus4 !== 32'h4) begin failures++; $display("FAIL reset_pc_plus4 got=%h exp=4", pc_plus4); end
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        logic [31:0] exp_cnt [3];
        exp_pc  = '{32'h0, 32'h4, 32'h8};
        exp_cnt = '{32'd0, 32'd1, 32'd2};
        PCWre = 1'b1; PCSrc = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc !== exp_pc[i] || instret !== exp_cnt[i]) begin
                failures++;
                $display("FAIL seq_step%0d pc=%h instret=%0d exp pc=%h instret=%0d",
                         i, pc, instret, exp_pc[i], exp_cnt[i]);
            end
        end
        checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL seq_imem_addr got=%h exp=8", imem_addr); end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 14; i++) step();
        checks++; if (pc !== 32'h40 || instret !== 32'd16) begin failures++; $display("FAIL br_setup pc=%h instret=%0d exp 40/16", pc, instret); end
        // load a backward branch, imm16 = -2
        PCWre = 1'b0; IRWre = 1'b1; rdata_drv = 32'h1000_FFFE;
        step();
        IRWre = 1'b0; rdata_drv = 32'h0;
        checks++; if (ir !== 32'h1000_FFFE) begin failures++; $display("FAIL br_ir_load got=%h exp=1000fffe", ir); end
        checks++; if (pc !== 32'h40 || instret !== 32'd16) begin failures++; $display("FAIL br_pc_held pc=%h instret=%0d exp 40/16", pc, instret); end
        PCWre = 1'b1; PCSrc = 2'b01;
        step();
        checks++; if (pc !== 32'h3C) begin failures++; $display("FAIL br_backward got=%h exp=3c", pc); end
        PCSrc = 2'b00;
        step();
        // forward branch, imm16 = 3
        PCWre = 1'b0; IRWre = 1'b1; rdata_drv = 32'h1000_0003;
        step();
        IRWre = 1'b0;
        PCWre = 1'b1; PCSrc = 2'b01;
        step();
        checks++; if (pc !== 32'h50) begin failures++; $display("FAIL br_forward got=%h exp=50", pc); end
        checks++; if (instret !== 32'd19) begin failures++; $display("FAIL br_instret got=%0d exp=19", instret); end
    endtask

    task automatic test_hold();
        PCWre = 1'b0; PCSrc = 2'b10; rs_data = 32'h0000_0003;
        step();
        step();
        checks++; if (pc !== 32'h50 || instret !== 32'd19) begin failures++; $display("FAIL hold_pc pc=%h instret=%0d exp 50/19", pc, instret); end
        checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL hold_misalign got=%b exp=0", misalign); end
    endtask

    task automatic test_jump();
        PCWre = 1'b1; PCSrc = 2'b10; rs_data = 32'hA000_0010;
        step();
        checks++; if (pc !== 32'hA000_0010) begin failures++; $display("FAIL jr_aligned got=%h exp=a0000010", pc); end
        checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL jr_aligned_misalign got=%b exp=0", misalign); end
        PCWre = 1'b0; IRWre = 1'b1; rdata_drv = 32'h0800_0100;
        step();
        IRWre = 1'b0;
        checks++; if (pc_plus4 !== 32'hA000_0014) begin failures++; $display("FAIL j_pc_plus4 got=%h exp=a0000014", pc_plus4); end
        PCWre = 1'b1; PCSrc = 2'b11;
        step();
        checks++; if (pc !== 32'hA000_0400) begin failures++; $display("FAIL j_target got=%h exp=a0000400", pc); end
        checks++; if (instret !== 32'd21) begin failures++; $display("FAIL j_instret got=%0d exp=21", instret); end
    endtask

    task automatic test_jr_misalign();
        PCWre = 1'b1; PCSrc = 2'b10; rs_data = 32'h0000_0123;
        step();
        checks++; if (pc !== 32'h0000_0120) begin failures++; $display("FAIL jr_low_bits got=%h exp=120", pc); end
        checks++; if (misalign !== 1'b1) begin failures++; $display("FAIL jr_misalign_set got=%b exp=1", misalign); end
        PCSrc = 2'b11;
        step();
        checks++; if (pc !== 32'h0000_0400) begin failures++; $display("FAIL j_after_jr got=%h exp=400", pc); end
        PCSrc = 2'b10; rs_data = 32'h0000_0200;
        step();
        checks++; if (pc !== 32'h200 || misalign !== 1'b1) begin failures++; $display("FAIL misalign_sticky pc=%h misalign=%b exp 200/1", pc, misalign); end
        checks++; if (instret !== 32'd24) begin failures++; $display("FAIL jr_instret got=%0d exp=24", instret); end
    endtask

    task automatic test_decode();
        PCWre = 1'b0; IRWre = 1'b1; rdata_drv = 32'h0441_0005;
        step();
        checks++; if (op !== 6'h01 || rs !== 5'd2 || rt !== 5'd1 || imm16 !== 16'h0005) begin
            failures++; $display("FAIL decode_bgez op=%h rs=%0d rt=%0d imm=%h exp 01/2/1/0005", op, rs, rt, imm16);
        end
        rdata_drv = 32'h0003_1080;
        step();
        checks++; if (op !== 6'h00 || rs !== 5'd0 || rt !== 5'd3 || rd !== 5'd2 || sa !== 5'd2 || imm16 !== 16'h1080) begin
            failures++; $display("FAIL decode_sll op=%h rs=%0d rt=%0d rd=%0d sa=%0d imm=%h exp 00/0/3/2/2/1080", op, rs, rt, rd, sa, imm16);
        end
        IRWre = 1'b0; rdata_drv = 32'hFFFF_FFFF;
        step();
        checks++; if (ir !== 32'h0003_1080) begin failures++; $display("FAIL ir_hold got=%h exp=00031080", ir); end
    endtask

    task automatic test_back_to_back();
        use_mem = 1'b1;
        PCWre = 1'b1; IRWre = 1'b1; PCSrc = 2'b00;
        step();
        checks++; if (ir !== 32'hDEAD_0200) begin failures++; $display("FAIL b2b_ir_old_pc got=%h exp=dead0200", ir); end
        checks++; if (pc !== 32'h204 || instret !== 32'd25) begin failures++; $display("FAIL b2b_pc pc=%h instret=%0d exp 204/25", pc, instret); end
        IRWre = 1'b0; use_mem = 1'b0;
    endtask

    task automatic test_reset_mid();
        PCWre = 1'b1; PCSrc = 2'b10; rs_data = 32'h0000_0080;
        step();
        checks++; if (pc !== 32'h80 || instret !== 32'd26) begin failures++; $display("FAIL mid_setup pc=%h instret=%0d exp 80/26", pc, instret); end
        PCSrc = 2'b00;
        #2 RST = 1'b0;
        #1;
        checks++; if (pc !== 32'h0 || ir !== 32'h0 || instret !== 32'h0 || misalign !== 1'b0) begin
            failures++; $display("FAIL mid_async pc=%h ir=%h instret=%0d misalign=%b exp all 0", pc, ir, instret, misalign);
        end
        @(negedge CLK);
        RST = 1'b1;
        step();
        checks++; if (pc !== 32'h0 || instret !== 32'd0) begin failures++; $display("FAIL refetch_hold pc=%h instret=%0d exp 0/0", pc, instret); end
        step();
        checks++; if (pc !== 32'h4 || instret !== 32'd1) begin failures++; $display("FAIL refetch_advance pc=%h instret=%0d exp 4/1", pc, instret); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_hold();
        test_jump();
        test_jr_misalign();
        test_decode();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
